// File: rtl/wb_arbiter.sv
// Write-back arbiter for the RV32E register file: LSU-priority merge of EXU/LSU results
// with an EXU anti-starvation guard, plus a busy scoreboard for RAW/WAW issue stalls.
// Optional perf counters are enabled by defining WB_PERF_EN.
module wb_arbiter #(
   parameter int NREG       = 16,
   parameter int AW         = 5,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          exu_valid,
   output logic          exu_ready,
   input  logic [AW-1:0] exu_rd,
   input  logic [DW-1:0] exu_data,
   input  logic          lsu_valid,
   output logic          lsu_ready,
   input  logic [AW-1:0] lsu_rd,
   input  logic [DW-1:0] lsu_data,
   output logic          rf_wen,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   input  logic [AW-1:0] iss_rs1,
   input  logic [AW-1:0] iss_rs2,
   input  logic [AW-1:0] iss_rd,
   input  logic          iss_rd_wen,
   input  logic          iss_fire,
   output logic          iss_stall
`ifdef WB_PERF_EN
   ,
   output logic [31:0]   perf_stall_cnt,
   output logic [31:0]   perf_conflict_cnt
`endif
);

   localparam int IW = $clog2(NREG);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [SW-1:0]   starve_cnt;
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic            exu_force;
   logic            grant;
   logic [AW-1:0]   win_rd;
   logic [DW-1:0]   win_data;
   logic            unused_hi;

   // Once EXU has lost STARVE_MAX times in a row it takes priority over LSU.
   assign exu_force = (starve_cnt == STARVE_LIM);
   assign exu_ready = exu_valid && (!lsu_valid || exu_force);
   assign lsu_ready = lsu_valid && !(exu_valid && exu_force);
   assign grant     = exu_ready || lsu_ready;
   assign win_rd    = exu_ready ? exu_rd   : lsu_rd;
   assign win_data  = exu_ready ? exu_data : lsu_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!exu_valid || exu_ready) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Writes to x0 are consumed but never reach the register file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_wen <= grant && (win_rd != '0);
         if (grant) begin
            rf_waddr <= win_rd;
            rf_wdata <= win_data;
         end
      end
   end

   // Clear on commit, then set on issue so a same-index set wins; bit 0 is pinned low.
   always_comb begin
      busy_nxt = busy;
      if (rf_wen) begin
         busy_nxt[rf_waddr[IW-1:0]] = 1'b0;
      end
      if (iss_fire && iss_rd_wen && (iss_rd != '0)) begin
         busy_nxt[iss_rd[IW-1:0]] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   assign iss_stall = busy[iss_rs1[IW-1:0]] | busy[iss_rs2[IW-1:0]] |
                      (iss_rd_wen & busy[iss_rd[IW-1:0]]);

   assign unused_hi = ^{iss_rs1[AW-1:IW], iss_rs2[AW-1:IW]};

`ifdef WB_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt    <= '0;
         perf_conflict_cnt <= '0;
      end else begin
         if (iss_stall) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (exu_valid && lsu_valid) begin
            perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: a cycle model predicts grants, stalls and the queue of
// expected register-file writes, which are popped and compared as the DUT commits them.
module tb_wb_arbiter;

   localparam int STARVE_MAX = 3;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        exu_valid, exu_ready, lsu_valid, lsu_ready;
   logic [4:0]  exu_rd, lsu_rd;
   logic [31:0] exu_data, lsu_data;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  iss_rs1, iss_rs2, iss_rd;
   logic        iss_rd_wen, iss_fire, iss_stall;
`ifdef WB_PERF_EN
   logic [31:0] perf_stall_cnt, perf_conflict_cnt;
`endif

   int          checks_total  = 0;
   int          checks_passed = 0;
   wr_t         exp_q[$];
   logic [15:0] mbusy;
   int          mstarve;
   logic        m_ew, m_lw;

   wb_arbiter dut (
      .clk(clk), .rst(rst),
      .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
      .iss_rd_wen(iss_rd_wen), .iss_fire(iss_fire), .iss_stall(iss_stall)
`ifdef WB_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks_total++;
      if (actual === expected) checks_passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   task automatic applyStimulus(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      exu_valid = ev; exu_rd = erd; exu_data = ed;
      lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
   endtask

   task automatic setIssue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic wen, input logic fire);
      iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_rd_wen = wen; iss_fire = fire;
   endtask

   function automatic logic refBusy(input logic [4:0] r);
      return (r != 5'd0) && mbusy[r[3:0]];
   endfunction

   // One clock of comparisons at the negedge, then the model advances across the posedge.
   task automatic stepCycle();
      wr_t  w;
      logic exp_wen;
      logic exp_stall;
      logic clr;
      logic [4:0] clr_addr;
      @(negedge clk);
      m_ew = exu_valid && (!lsu_valid || mstarve == STARVE_MAX);
      m_lw = lsu_valid && !(exu_valid && mstarve == STARVE_MAX);
      checkOutput("exu_ready", 32'(exu_ready), 32'(m_ew));
      checkOutput("lsu_ready", 32'(lsu_ready), 32'(m_lw));
      exp_stall = refBusy(iss_rs1) | refBusy(iss_rs2) | (iss_rd_wen & refBusy(iss_rd));
      checkOutput("iss_stall", 32'(iss_stall), 32'(exp_stall));
      exp_wen = (exp_q.size() > 0);
      checkOutput("rf_wen", 32'(rf_wen), 32'(exp_wen));
      clr = 1'b0;
      clr_addr = 5'd0;
      if (exp_wen) begin
         w = exp_q.pop_front();
         checkOutput("rf_waddr", 32'(rf_waddr), 32'(w.addr));
         checkOutput("rf_wdata", rf_wdata, w.data);
         clr = 1'b1;
         clr_addr = w.addr;
      end
      if (m_ew && exu_rd != 5'd0) exp_q.push_back('{addr: exu_rd, data: exu_data});
      else if (m_lw && lsu_rd != 5'd0) exp_q.push_back('{addr: lsu_rd, data: lsu_data});
      if (!exu_valid || m_ew) mstarve = 0;
      else if (mstarve < STARVE_MAX) mstarve++;
      if (clr) mbusy[clr_addr[3:0]] = 1'b0;
      if (iss_fire && iss_rd_wen && iss_rd != 5'd0) mbusy[iss_rd[3:0]] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   exu_win_at;
      logic ev_pend, lv_pend;
      logic [4:0] lrd;

      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0);
      setIssue(0, 0, 0, 0, 0);
      mbusy = '0; mstarve = 0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_wen",   32'(rf_wen), 0);
      checkOutput("rst_waddr", 32'(rf_waddr), 0);
      checkOutput("rst_wdata", rf_wdata, 0);
      checkOutput("rst_stall", 32'(iss_stall), 0);
      checkOutput("rst_ready", 32'({exu_ready, lsu_ready}), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single EXU write
      applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      stepCycle();
      stepCycle();
      checkOutput("hold_addr", 32'(rf_waddr), 5);
      checkOutput("hold_data", rf_wdata, 32'hDEADBEEF);

      // Conflict: LSU first, then EXU
      applyStimulus(1, 4, 32'h22, 1, 3, 32'h11);
      stepCycle();
      applyStimulus(1, 4, 32'h22, 0, 0, 0);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      stepCycle();
      checkOutput("conflict_last", 32'(rf_waddr), 4);
      stepCycle();

      // Starvation: LSU offers six requests while EXU holds one
      exu_win_at = -1;
      ev_pend = 1'b1;
      lrd = 5'd1;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(ev_pend, 7, 32'hE7, 1, lrd, 32'h100 + 32'(lrd));
         stepCycle();
         if (m_ew) begin
            ev_pend = 1'b0;
            if (exu_win_at < 0) exu_win_at = i;
         end
         if (m_lw) lrd = lrd + 5'd1;
      end
      checkOutput("starve_win_cycle", 32'(exu_win_at), 3);
      applyStimulus(0, 0, 0, 0, 0, 0);
      stepCycle();
      stepCycle();

      // RAW / WAW hazard on x10
      setIssue(0, 0, 10, 1, 1);
      stepCycle();
      setIssue(10, 0, 0, 0, 0);
      #1 checkOutput("raw_stall", 32'(iss_stall), 1);
      stepCycle();
      setIssue(0, 0, 10, 1, 0);
      #1 checkOutput("waw_stall", 32'(iss_stall), 1);
      stepCycle();
      setIssue(10, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 10, 32'hAA);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      #1 checkOutput("raw_stall_t1", 32'(iss_stall), 1);
      stepCycle();
      #1 checkOutput("raw_clear_t2", 32'(iss_stall), 0);
      stepCycle();

      // x0 handling
      applyStimulus(1, 0, 32'h55, 0, 0, 0);
      setIssue(0, 0, 0, 1, 1);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      setIssue(0, 0, 0, 0, 0);
      #1 checkOutput("x0_no_wen", 32'(rf_wen), 0);
      checkOutput("x0_no_stall", 32'(iss_stall), 0);
      stepCycle();

      // Random traffic with legal handshakes
      ev_pend = 1'b0;
      lv_pend = 1'b0;
      for (int i = 0; i < 260; i++) begin
         if (i < 240 && !ev_pend && $urandom_range(1) == 1) begin
            ev_pend = 1'b1;
            exu_rd = 5'($urandom_range(15));
            exu_data = $urandom;
         end
         if (i < 240 && !lv_pend && $urandom_range(1) == 1) begin
            lv_pend = 1'b1;
            lsu_rd = 5'($urandom_range(15));
            lsu_data = $urandom;
         end
         exu_valid = ev_pend;
         lsu_valid = lv_pend;
         setIssue(5'($urandom_range(15)), 5'($urandom_range(15)), 5'($urandom_range(15)),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
         stepCycle();
         if (m_ew) ev_pend = 1'b0;
         if (m_lw) lv_pend = 1'b0;
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      setIssue(0, 0, 0, 0, 0);
      stepCycle();

      // Reset mid-operation drops the in-flight write and all busy bits
      applyStimulus(1, 9, 32'h99, 0, 0, 0);
      setIssue(0, 0, 7, 1, 1);
      stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      setIssue(7, 0, 0, 0, 0);
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_wen", 32'(rf_wen), 0);
      checkOutput("rst_mid_stall", 32'(iss_stall), 0);
      exp_q.delete();
      mbusy = '0;
      mstarve = 0;
      #1 rst = 1'b0;
      stepCycle();
      stepCycle();
      checkOutput("queue_empty", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
